// File: rtl/mesh_router_input_decode.sv
// Input stage of one mesh router port: buffers flits in a small FIFO, computes the
// X-then-Y output direction at accept time and drops flits whose turn is not legal here.
module mesh_router_input_decode #(
  parameter int width_p        = 32,
  parameter int x_cord_width_p = 4,
  parameter int y_cord_width_p = 4,
  parameter int dims_p         = 2,
  parameter int els_p          = 2,
  parameter logic [dims_p*2:0] routing_matrix_row_p = '1
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic [x_cord_width_p-1:0] my_x_i,
  input  logic [y_cord_width_p-1:0] my_y_i,
  input  logic [width_p-1:0]        data_i,
  input  logic                      v_i,
  output logic                      ready_o,
  output logic [width_p-1:0]        data_o,
  output logic [dims_p*2:0]         dir_oh_o,
  output logic                      v_o,
  input  logic                      yumi_i,
  output logic                      error_o,
  output logic [7:0]                drop_count_o
);

  localparam int dirs_lp = dims_p*2+1;
  localparam int ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int cnt_w_lp = $clog2(els_p+1);

  logic [width_p-1:0]  data_mem_q [els_p];
  logic [dirs_lp-1:0]  dir_mem_q  [els_p];
  logic [ptr_w_lp-1:0] rptr_q, rptr_d, wptr_q, wptr_d;
  logic [cnt_w_lp-1:0] cnt_q, cnt_d;
  logic                error_q, error_d;
  logic [7:0]          drops_q, drops_d;

  logic [x_cord_width_p-1:0] dest_x;
  logic [y_cord_width_p-1:0] dest_y;
  logic [4:0]                route_oh5;
  logic [dirs_lp-1:0]        route_oh;
  logic                      full, accept, legal, enq, deq;

  assign dest_x = data_i[x_cord_width_p-1:0];
  assign dest_y = data_i[x_cord_width_p+y_cord_width_p-1:x_cord_width_p];

  // Direction is built in the full 5-bit encoding, then trimmed to the mesh's dirs.
  always_comb begin
    route_oh5 = 5'b00001;
    if (dest_x < my_x_i)                         route_oh5 = 5'b00010;
    else if (dest_x > my_x_i)                    route_oh5 = 5'b00100;
    else if ((dims_p == 2) && (dest_y < my_y_i)) route_oh5 = 5'b01000;
    else if ((dims_p == 2) && (dest_y > my_y_i)) route_oh5 = 5'b10000;
  end

  assign route_oh = route_oh5[dirs_lp-1:0];
  assign legal    = |(route_oh & routing_matrix_row_p);
  assign full     = (cnt_q == cnt_w_lp'(els_p));
  assign ready_o  = !full && !reset_i;
  assign accept   = v_i && ready_o;
  assign enq      = accept && legal;
  assign v_o      = (cnt_q != '0) && !reset_i;
  assign deq      = yumi_i && v_o;

  always_comb begin
    rptr_d  = rptr_q;
    wptr_d  = wptr_q;
    cnt_d   = cnt_q;
    error_d = error_q;
    drops_d = drops_q;
    if (enq) wptr_d = (wptr_q == ptr_w_lp'(els_p-1)) ? '0 : wptr_q + 1'b1;
    if (deq) rptr_d = (rptr_q == ptr_w_lp'(els_p-1)) ? '0 : rptr_q + 1'b1;
    if (enq && !deq)      cnt_d = cnt_q + 1'b1;
    else if (!enq && deq) cnt_d = cnt_q - 1'b1;
    if (accept && !legal) begin
      error_d = 1'b1;
      if (drops_q != 8'hFF) drops_d = drops_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      cnt_q   <= '0;
      error_q <= 1'b0;
      drops_q <= '0;
    end else begin
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      cnt_q   <= cnt_d;
      error_q <= error_d;
      drops_q <= drops_d;
    end
  end

  // Storage needs no reset: nothing is read unless the occupancy count says it is valid.
  always_ff @(posedge clk_i) begin
    if (enq) begin
      data_mem_q[wptr_q] <= data_i;
      dir_mem_q[wptr_q]  <= route_oh;
    end
  end

  assign data_o       = data_mem_q[rptr_q];
  assign dir_oh_o     = v_o ? dir_mem_q[rptr_q] : '0;
  assign error_o      = error_q && !reset_i;
  assign drop_count_o = reset_i ? 8'd0 : drops_q;

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (!reset_i) assert (!(yumi_i && !v_o));
    assert ((dims_p == 1) || (dims_p == 2));
    assert (els_p >= 2);
  end
`endif

endmodule

// File: tb/tb_mesh_router_input_decode.sv
// Bench for mesh_router_input_decode: directed scenarios plus randomized traffic checked
// against a queue-based model, on an all-ones port and a port with W/E turns forbidden.
module tb_mesh_router_input_decode;

  localparam int ELS = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0, v = 1'b0, yumi = 1'b0, sel = 1'b0;
  logic [31:0] din = '0;
  logic [3:0]  myX = 4'd2, myY = 4'd2;

  logic        readyA, vA, errA, readyB, vB, errB;
  logic [31:0] dataA, dataB;
  logic [4:0]  dirA, dirB;
  logic [7:0]  dropsA, dropsB;

  wire        readyO = sel ? readyB : readyA;
  wire        vO     = sel ? vB     : vA;
  wire        errO   = sel ? errB   : errA;
  wire [31:0] dataO  = sel ? dataB  : dataA;
  wire [4:0]  dirO   = sel ? dirB   : dirA;
  wire [7:0]  dropsO = sel ? dropsB : dropsA;

  always #5 clk = ~clk;

  mesh_router_input_decode #(.els_p(ELS), .routing_matrix_row_p(5'b11111)) dutA (
    .clk_i(clk), .reset_i(rst), .my_x_i(myX), .my_y_i(myY), .data_i(din),
    .v_i(v && !sel), .ready_o(readyA), .data_o(dataA), .dir_oh_o(dirA), .v_o(vA),
    .yumi_i(yumi && !sel), .error_o(errA), .drop_count_o(dropsA));

  mesh_router_input_decode #(.els_p(ELS), .routing_matrix_row_p(5'b11001)) dutB (
    .clk_i(clk), .reset_i(rst), .my_x_i(myX), .my_y_i(myY), .data_i(din),
    .v_i(v && sel), .ready_o(readyB), .data_o(dataB), .dir_oh_o(dirB), .v_o(vB),
    .yumi_i(yumi && sel), .error_o(errB), .drop_count_o(dropsB));

  typedef struct { logic [31:0] d; logic [4:0] dir; } entry_t;
  entry_t mq[$];
  bit     mErr;
  int     mDrops;
  int     vectors = 0;
  int     miscompares = 0;

  // Dimension-ordered route: resolve X first, then Y, else deliver locally.
  function automatic logic [4:0] refRoute(input logic [31:0] d);
    int dx, dy;
    dx = int'(d[3:0]);
    dy = int'(d[7:4]);
    if (dx < int'(myX)) return 5'b00010;
    if (dx > int'(myX)) return 5'b00100;
    if (dy < int'(myY)) return 5'b01000;
    if (dy > int'(myY)) return 5'b10000;
    return 5'b00001;
  endfunction

  function automatic logic [31:0] mk(input int x, input int y, input int tag);
    logic [31:0] f;
    f = {tag[23:0], y[3:0], x[3:0]};
    return f;
  endfunction

  // Drives one cycle of inputs and advances the model; returns #1 after the edge.
  task automatic applyStimulus(input bit r, input bit vv, input logic [31:0] dd, input bit yy);
    bit         acc;
    logic [4:0] oh, row;
    entry_t     e;
    @(negedge clk);
    rst = r; v = vv; din = dd; yumi = yy;
    if (r) begin
      mq.delete(); mErr = 0; mDrops = 0;
    end else begin
      acc = vv && (mq.size() < ELS);
      if (yy && mq.size() > 0) void'(mq.pop_front());
      if (acc) begin
        oh  = refRoute(dd);
        row = sel ? 5'b11001 : 5'b11111;
        if ((oh & row) != 0) begin
          e.d = dd; e.dir = oh; mq.push_back(e);
        end else begin
          mErr = 1;
          mDrops = (mDrops < 255) ? mDrops + 1 : 255;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    sel = 0;
    applyStimulus(1, 0, '0, 0);
    applyStimulus(1, 0, '0, 0);
    vectors++; if (vO !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_v: got %0h want 0", vO); end
    vectors++; if (dirO !== 5'b0) begin miscompares++; $display("[TB] FAIL reset_dir: got %0h want 0", dirO); end
    vectors++; if (readyO !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_ready: got %0h want 0", readyO); end
    vectors++; if (errO !== 1'b0 || dropsO !== 8'd0) begin miscompares++; $display("[TB] FAIL reset_err: got err=%0h drops=%0d want 0/0", errO, dropsO); end
    applyStimulus(0, 0, '0, 0);
    vectors++; if (readyO !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_release_ready: got %0h want 1", readyO); end
  endtask

  task automatic test_routing();
    int         xs[5]  = '{1, 3, 2, 2, 2};
    int         ys[5]  = '{5, 0, 1, 3, 2};
    logic [4:0] exp[5] = '{5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b00001};
    logic [31:0] f;
    myX = 2; myY = 2;
    for (int i = 0; i < 5; i++) begin
      f = mk(xs[i], ys[i], 16'h100 + i);
      applyStimulus(0, 1, f, 0);
      vectors++; if (vO !== 1'b1) begin miscompares++; $display("[TB] FAIL route_v[%0d]: got %0h want 1", i, vO); end
      vectors++; if (dirO !== exp[i]) begin miscompares++; $display("[TB] FAIL route_dir[%0d]: got %b want %b", i, dirO, exp[i]); end
      vectors++; if (dataO !== f) begin miscompares++; $display("[TB] FAIL route_data[%0d]: got %h want %h", i, dataO, f); end
      applyStimulus(0, 0, '0, 1);
      vectors++; if (vO !== 1'b0 || dirO !== 5'b0) begin miscompares++; $display("[TB] FAIL route_drain[%0d]: got v=%0h dir=%b want 0", i, vO, dirO); end
    end
  endtask

  task automatic test_illegal();
    sel = 1; myX = 2; myY = 2;
    applyStimulus(1, 0, '0, 0);
    applyStimulus(0, 1, mk(3, 2, 'h55), 0);
    vectors++; if (vO !== 1'b0) begin miscompares++; $display("[TB] FAIL illegal_v: got %0h want 0", vO); end
    vectors++; if (errO !== 1'b1) begin miscompares++; $display("[TB] FAIL illegal_err: got %0h want 1", errO); end
    vectors++; if (dropsO !== 8'd1) begin miscompares++; $display("[TB] FAIL illegal_drops: got %0d want 1", dropsO); end
    applyStimulus(0, 1, mk(2, 3, 'h66), 0);
    vectors++; if (vO !== 1'b1 || dirO !== 5'b10000) begin miscompares++; $display("[TB] FAIL illegal_then_legal: got v=%0h dir=%b want 1/10000", vO, dirO); end
    applyStimulus(0, 0, '0, 1);
  endtask

  task automatic test_backpressure();
    logic [31:0] a, b, c;
    a = mk(1, 5, 'hA); b = mk(3, 0, 'hB); c = mk(2, 1, 'hC);
    sel = 0;
    applyStimulus(1, 0, '0, 0);
    applyStimulus(0, 1, a, 0);
    vectors++; if (readyO !== 1'b1 || dataO !== a) begin miscompares++; $display("[TB] FAIL bp_first: got ready=%0h data=%h want 1/%h", readyO, dataO, a); end
    applyStimulus(0, 1, b, 0);
    vectors++; if (readyO !== 1'b0) begin miscompares++; $display("[TB] FAIL bp_full_ready: got %0h want 0", readyO); end
    applyStimulus(0, 1, c, 0);
    vectors++; if (readyO !== 1'b0 || dataO !== a) begin miscompares++; $display("[TB] FAIL bp_held: got ready=%0h data=%h want 0/%h", readyO, dataO, a); end
    applyStimulus(0, 1, c, 1);
    vectors++; if (readyO !== 1'b1 || dataO !== b) begin miscompares++; $display("[TB] FAIL bp_nobypass: got ready=%0h data=%h want 1/%h", readyO, dataO, b); end
    applyStimulus(0, 1, c, 0);
    vectors++; if (readyO !== 1'b0 || dataO !== b) begin miscompares++; $display("[TB] FAIL bp_refill: got ready=%0h data=%h want 0/%h", readyO, dataO, b); end
    applyStimulus(0, 0, '0, 1);
    vectors++; if (dataO !== c || dirO !== 5'b01000) begin miscompares++; $display("[TB] FAIL bp_order_c: got data=%h dir=%b want %h/01000", dataO, dirO, c); end
    applyStimulus(0, 0, '0, 1);
    vectors++; if (vO !== 1'b0) begin miscompares++; $display("[TB] FAIL bp_empty: got %0h want 0", vO); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] f;
    sel = 0;
    applyStimulus(0, 1, mk(0, 0, 'h200), 0);
    for (int k = 1; k <= 10; k++) begin
      f = mk(k % 5, (k * 3) % 5, 'h200 + k);
      applyStimulus(0, 1, f, 1);
      vectors++; if (vO !== 1'b1 || dataO !== f || readyO !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b[%0d]: got v=%0h data=%h ready=%0h want 1/%h/1", k, vO, dataO, readyO, f); end
    end
    applyStimulus(0, 0, '0, 1);
    vectors++; if (vO !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_drain: got %0h want 0", vO); end
  endtask

  task automatic test_saturation();
    sel = 1; myX = 2; myY = 2;
    applyStimulus(1, 0, '0, 0);
    for (int i = 0; i < 300; i++) begin
      applyStimulus(0, 1, mk(0, 2, i), 0);
      if (i == 99) begin
        vectors++; if (dropsO !== 8'd100) begin miscompares++; $display("[TB] FAIL sat_mid: got %0d want 100", dropsO); end
      end
    end
    vectors++; if (dropsO !== 8'd255 || errO !== 1'b1) begin miscompares++; $display("[TB] FAIL sat_end: got drops=%0d err=%0h want 255/1", dropsO, errO); end
    vectors++; if (vO !== 1'b0 || readyO !== 1'b1) begin miscompares++; $display("[TB] FAIL sat_nofwd: got v=%0h ready=%0h want 0/1", vO, readyO); end
  endtask

  task automatic test_reset_mid();
    sel = 1;
    applyStimulus(0, 1, mk(2, 2, 'h301), 0);
    applyStimulus(0, 1, mk(2, 4, 'h302), 0);
    vectors++; if (readyO !== 1'b0 || vO !== 1'b1 || errO !== 1'b1) begin miscompares++; $display("[TB] FAIL rmid_pre: got ready=%0h v=%0h err=%0h want 0/1/1", readyO, vO, errO); end
    applyStimulus(1, 0, '0, 0);
    vectors++; if (vO !== 1'b0 || readyO !== 1'b0 || errO !== 1'b0 || dirO !== 5'b0) begin miscompares++; $display("[TB] FAIL rmid_during: got v=%0h ready=%0h err=%0h dir=%b want 0/0/0/0", vO, readyO, errO, dirO); end
    applyStimulus(0, 0, '0, 0);
    vectors++; if (vO !== 1'b0 || errO !== 1'b0 || dropsO !== 8'd0 || readyO !== 1'b1) begin miscompares++; $display("[TB] FAIL rmid_after: got v=%0h err=%0h drops=%0d ready=%0h want 0/0/0/1", vO, errO, dropsO, readyO); end
  endtask

  task automatic test_random(input bit which, input int cycles);
    logic [31:0] r32, dd;
    bit          vv, yy, rr;
    sel = which;
    r32 = $urandom; myX = 4'(r32 % 5); myY = 4'((r32 >> 8) % 5);
    applyStimulus(1, 0, '0, 0);
    for (int n = 0; n < cycles; n++) begin
      r32 = $urandom;
      dd  = {r32[31:8], 4'($urandom_range(0, 4)), 4'($urandom_range(0, 4))};
      vv  = ($urandom_range(0, 3) != 0);
      yy  = (mq.size() > 0) && ($urandom_range(0, 2) != 0);
      rr  = ($urandom_range(0, 99) == 0);
      applyStimulus(rr, vv, dd, yy);
      vectors++; if (readyO !== (!rr && mq.size() < ELS)) begin miscompares++; $display("[TB] FAIL rnd_ready[%0d]: got %0h want %0h", n, readyO, (!rr && mq.size() < ELS)); end
      vectors++; if (vO !== (mq.size() > 0)) begin miscompares++; $display("[TB] FAIL rnd_v[%0d]: got %0h want %0h", n, vO, (mq.size() > 0)); end
      if (mq.size() > 0) begin
        vectors++; if (dataO !== mq[0].d || dirO !== mq[0].dir) begin miscompares++; $display("[TB] FAIL rnd_head[%0d]: got %h/%b want %h/%b", n, dataO, dirO, mq[0].d, mq[0].dir); end
      end else begin
        vectors++; if (dirO !== 5'b0) begin miscompares++; $display("[TB] FAIL rnd_dir_idle[%0d]: got %b want 0", n, dirO); end
      end
      vectors++; if (errO !== mErr || dropsO !== 8'(mDrops)) begin miscompares++; $display("[TB] FAIL rnd_err[%0d]: got %0h/%0d want %0h/%0d", n, errO, dropsO, mErr, mDrops); end
      if (rr) applyStimulus(0, 0, '0, 0);
    end
    while (mq.size() > 0) applyStimulus(0, 0, '0, 1);
  endtask

  initial begin
    mErr = 0; mDrops = 0;
    test_reset();
    test_routing();
    test_illegal();
    test_backpressure();
    test_back_to_back();
    test_saturation();
    test_reset_mid();
    test_random(0, 600);
    test_random(1, 600);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
